// File: rtl/dmem_resp.sv
// Data-memory responder: word array with byte lanes, write-first forwarding, range check,
// fixed read latency (RD_LAT 1 or 2) and saturating access counters. Optional parity via DMEM_RESP_PARITY_EN.
module dmem_resp #(
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      dat_a,
   input  logic [3:0]       dat_we,
   input  logic [31:0]      dat_wd,
   input  logic [3:0]       dat_re,
   output logic [31:0]      dat_rd,
   output logic             dat_rvld,
   output logic             dat_err,
   input  logic             par_inj,
   output logic             par_err,
   output logic [CNT_W-1:0] cnt_rd,
   output logic [CNT_W-1:0] cnt_wr
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [13:0]   widx;
   logic [AW-1:0] aidx;
   logic          in_range;
   logic          rd_req;
   logic          wr_en;
   logic [31:0]   merged;
   logic [31:0]   rd_word;
   logic          par_bad;
   logic          unused_bits;

   logic [31:0]   mem [DEPTH];

   assign widx        = dat_a[15:2];
   assign aidx        = widx[AW-1:0];
   assign in_range    = (32'(widx) < 32'(DEPTH));
   assign rd_req      = |dat_re;
   assign wr_en       = (|dat_we) & in_range;
   assign unused_bits = ^{par_inj, dat_a[1:0]};

   // Array write; lanes without an enable keep their contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (dat_we[i]) begin
               mem[aidx][8*i +: 8] <= dat_wd[8*i +: 8];
            end
         end
      end
   end

   // Write-first merge of the addressed word, then read-lane masking.
   always_comb begin
      merged  = mem[aidx];
      rd_word = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         if (dat_we[i]) begin
            merged[8*i +: 8] = dat_wd[8*i +: 8];
         end else begin
            merged[8*i +: 8] = mem[aidx][8*i +: 8];
         end
         if (dat_re[i] && in_range) begin
            rd_word[8*i +: 8] = merged[8*i +: 8];
         end else begin
            rd_word[8*i +: 8] = 8'h00;
         end
      end
   end

`ifdef DMEM_RESP_PARITY_EN
   logic [3:0] par_mem [DEPTH];
   logic [3:0] merged_par;

   // Even parity per written lane; injection flips the stored bit.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (dat_we[i]) begin
               par_mem[aidx][i] <= (^dat_wd[8*i +: 8]) ^ par_inj;
            end
         end
      end
   end

   // Parity check over enabled lanes of the merged word.
   always_comb begin
      merged_par = par_mem[aidx];
      par_bad    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (dat_we[i]) begin
            merged_par[i] = (^dat_wd[8*i +: 8]) ^ par_inj;
         end else begin
            merged_par[i] = par_mem[aidx][i];
         end
         if (dat_re[i] && in_range && ((^merged[8*i +: 8]) ^ merged_par[i])) begin
            par_bad = 1'b1;
         end else begin
            par_bad = par_bad;
         end
      end
   end
`else
   assign par_bad = 1'b0;
`endif

   logic        s1_vld;
   logic [31:0] s1_data;
   logic        s1_err;
   logic        par_err_r;

   // First read stage: captures the array read; data holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_data   <= 32'h0000_0000;
         s1_err    <= 1'b0;
         par_err_r <= 1'b0;
      end else begin
         s1_vld <= rd_req;
         if (rd_req) begin
            s1_data <= rd_word;
            s1_err  <= ~in_range | par_bad;
         end else begin
            s1_err  <= 1'b0;
         end
         if (rd_req && par_bad) begin
            par_err_r <= 1'b1;
         end
      end
   end

   assign par_err = par_err_r;

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic        s2_vld;
         logic [31:0] s2_data;
         logic        s2_err;

         // Extra output register stage.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_vld  <= 1'b0;
               s2_data <= 32'h0000_0000;
               s2_err  <= 1'b0;
            end else begin
               s2_vld <= s1_vld;
               s2_err <= s1_vld & s1_err;
               if (s1_vld) begin
                  s2_data <= s1_data;
               end
            end
         end

         assign dat_rd   = s2_data;
         assign dat_rvld = s2_vld;
         assign dat_err  = s2_err;
      end else begin : g_lat1
         assign dat_rd   = s1_data;
         assign dat_rvld = s1_vld;
         assign dat_err  = s1_err;
      end
   endgenerate

   // Saturating request counters; out-of-range requests still count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_rd <= {CNT_W{1'b0}};
         cnt_wr <= {CNT_W{1'b0}};
      end else begin
         if (rd_req && (cnt_rd != CNT_MAX)) begin
            cnt_rd <= cnt_rd + CNT_ONE;
         end
         if ((|dat_we) && (cnt_wr != CNT_MAX)) begin
            cnt_wr <= cnt_wr + CNT_ONE;
         end
      end
   end
endmodule
